// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request-legality helpers.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_t;

  function automatic logic funct3_ok(input logic store, input logic [2:0] f3);
    if (store) return f3 <= SW;
    return (f3 != 3'd3) && (f3 <= LHU);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of request, response and memory-side signals of the load/store unit.
interface lsu_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic              req_store;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readword;

  modport slave (
    input  req_valid, req_funct3, req_store, req_addr, req_wdata,
    input  resp_ready, mem_readword,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write, mem_writedata
  );

  modport master (
    output req_valid, req_funct3, req_store, req_addr, req_wdata,
    output resp_ready, mem_readword,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write, mem_writedata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  bytes [4];
  logic [15:0] halves [2];
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign bytes[gi] = word[8*gi +: 8];
      // Byte gi takes store data when it is the SB lane or inside the SH half.
      assign merged_word[8*gi +: 8] =
        ((funct3[1:0] == 2'd0) && (lane == 2'(gi)))       ? wdata[7:0] :
        ((funct3[1:0] == 2'd1) && (lane[1] == 1'(gi / 2))) ? wdata[8*(gi % 2) +: 8] :
                                                              bytes[gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_halves
      assign halves[gi] = word[16*gi +: 16];
    end
  endgenerate

  assign b_sel = bytes[lane];
  assign h_sel = halves[lane[1]];

  always_comb begin
    load_data = word;
    case (funct3)
      LB:      load_data = {{24{b_sel[7]}}, b_sel};
      LH:      load_data = {{16{h_sel[15]}}, h_sel};
      LBU:     load_data = {24'd0, b_sel};
      LHU:     load_data = {16'd0, h_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/lsu_core.sv
// Load/store unit in front of the word-wide data memory.
// Optional LSU_RANGE_CHECK_EN: reject addresses with bits above ADDR_W set.
module lsu_core
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic  clock,
  input logic  reset,
  lsu_if.slave bus
);

  lsu_state_t        state_reg, state_next;
  logic [2:0]        funct3_reg;
  logic              store_reg;
  logic [31:0]       wdata_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;
  logic              accept;
  logic              req_bad;
  logic              out_of_range;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

`ifdef LSU_RANGE_CHECK_EN
  assign out_of_range = |bus.req_addr[31:ADDR_W];
`else
  logic unused_upper;
  assign unused_upper = ^bus.req_addr[31:ADDR_W];
  assign out_of_range = 1'b0;
`endif

  assign accept  = (state_reg == IDLE) && bus.req_valid;
  assign req_bad = misaligned(bus.req_funct3, bus.req_addr[1:0])
                 || !funct3_ok(bus.req_store, bus.req_funct3)
                 || out_of_range;

  lsu_align u_align (
    .funct3      (funct3_reg),
    .lane        (addr_reg[1:0]),
    .word        (bus.mem_readword),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_write = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_bad)                                     state_next = RESP;
          else if (bus.req_store && bus.req_funct3 == SW)  state_next = WR;
          else                                             state_next = RD;
        end
      end
      RD:  state_next = CAP;
      CAP: state_next = store_reg ? WR : RESP;
      WR: begin
        bus.mem_write = !reset;
        state_next    = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Rejected requests leave the memory address and write data untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      funct3_reg    <= 3'd0;
      store_reg     <= 1'b0;
      wdata_reg     <= 32'd0;
      addr_reg      <= '0;
      mem_wdata_reg <= 32'd0;
      rdata_reg     <= 32'd0;
      err_reg       <= 1'b0;
    end else if (accept) begin
      funct3_reg <= bus.req_funct3;
      store_reg  <= bus.req_store;
      wdata_reg  <= bus.req_wdata;
      rdata_reg  <= 32'd0;
      err_reg    <= req_bad;
      if (!req_bad) begin
        addr_reg <= bus.req_addr[ADDR_W-1:0];
        if (bus.req_store && bus.req_funct3 == SW) mem_wdata_reg <= bus.req_wdata;
      end
    end else if (state_reg == CAP) begin
      if (store_reg) mem_wdata_reg <= merged_word;
      else           rdata_reg     <= load_data;
    end
  end

  assign bus.mem_address   = addr_reg;
  assign bus.mem_writedata = mem_wdata_reg;
  assign bus.resp_rdata    = rdata_reg;
  assign bus.resp_err      = err_reg;

endmodule
